// File: rtl/cell_activity_scheduler.sv
// Purpose: per-frame foreground counter for the five overlay cells; selects and holds the most active cell.
// Latency: frame_done to sel_pulse is 7 cycles; highlight is registered 1 cycle after the pixel sample.
// Backpressure: none; pixels are ignored outside ACCUM and busy flags that window. Optional macro: CELL_HYST_EN.
module cell_activity_scheduler #(
  parameter int BOX_TL_X    = 100,
  parameter int BOX_TL_Y    = 100,
  parameter int BOX_SIDE    = 80,
  parameter int CELL_PITCH  = 85,
  parameter int THRESH      = 200,
  parameter int HOLD_FRAMES = 30,
  parameter int HYST        = 100,
  parameter int CNT_W       = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_valid,
  input  logic [30:0] hCounter_in,
  input  logic [30:0] vCounter_in,
  input  logic        fg_pixel,
  input  logic        frame_done,
  output logic [2:0]  active_cell,
  output logic        cell_valid,
  output logic        sel_pulse,
  output logic        highlight,
  output logic        busy
);

`ifdef CELL_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  localparam int                HOLD_W   = $clog2(HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0] HOLD_VAL = HOLD_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0]  THR_VAL  = CNT_W'(THRESH);
  localparam logic [CNT_W:0]    HYST_M   = (CNT_W+1)'(HYST);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [30:0]       Y_LO     = 31'(BOX_TL_Y);
  localparam logic [30:0]       Y_HI     = 31'(BOX_TL_Y + BOX_SIDE);

  typedef enum logic [1:0] {ACCUM, EVAL, UPDATE} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt [5];
  logic [2:0]        r_eval_k;
  logic [2:0]        r_best_idx;
  logic [CNT_W-1:0]  r_best_cnt;
  logic [2:0]        r_active_cell;
  logic              r_cell_valid;
  logic              r_sel_pulse;
  logic              r_highlight;
  logic [HOLD_W-1:0] r_hold;

  logic [4:0]        w_in_cell;
  logic              w_in_y;
  logic              w_hl_hit;
  logic [CNT_W-1:0]  w_eval_cnt;
  logic [CNT_W-1:0]  w_act_cnt;
  logic              w_win;
  logic              w_refresh;

  // Interior hit test per cell, plus the current scan/active cell counts and the selected-cell hit.
  always_comb begin
    w_in_y     = (vCounter_in >= Y_LO) && (vCounter_in < Y_HI);
    w_in_cell  = '0;
    w_eval_cnt = '0;
    w_act_cnt  = '0;
    w_hl_hit   = 1'b0;
    for (int k = 0; k < 5; k++) begin
      w_in_cell[k] = w_in_y &&
                     (hCounter_in >= 31'(BOX_TL_X + k*CELL_PITCH)) &&
                     (hCounter_in <  31'(BOX_TL_X + k*CELL_PITCH + BOX_SIDE));
      if (r_eval_k == 3'(k))      w_eval_cnt = r_cnt[k];
      if (r_active_cell == 3'(k)) begin
        w_act_cnt = r_cnt[k];
        w_hl_hit  = w_in_cell[k];
      end
    end
  end

  // Winner decision for UPDATE; a non-incumbent challenger must clear the hysteresis margin when enabled.
  always_comb begin
    w_win     = (r_best_cnt >= THR_VAL);
    w_refresh = 1'b0;
    if (HYST_ON && w_win && r_cell_valid && (r_best_idx != r_active_cell) &&
        ({1'b0, r_best_cnt} <= ({1'b0, w_act_cnt} + HYST_M))) begin
      w_win     = 1'b0;
      w_refresh = (w_act_cnt >= THR_VAL);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACCUM;
    else     r_state <= w_next;
  end

  // Next-state logic and busy flag.
  always_comb begin
    w_next = r_state;
    busy   = (r_state != ACCUM);
    case (r_state)
      ACCUM:   if (frame_done) w_next = EVAL;
      EVAL:    if (r_eval_k == 3'd4) w_next = UPDATE;
      UPDATE:  w_next = ACCUM;
      default: w_next = ACCUM;
    endcase
  end

  // Counting, best-cell scan and selection/hold bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 5; k++) r_cnt[k] <= '0;
      r_eval_k      <= '0;
      r_best_idx    <= '0;
      r_best_cnt    <= '0;
      r_active_cell <= '0;
      r_cell_valid  <= 1'b0;
      r_sel_pulse   <= 1'b0;
      r_hold        <= '0;
    end else begin
      r_sel_pulse <= 1'b0;
      case (r_state)
        ACCUM: begin
          for (int k = 0; k < 5; k++)
            if (pix_valid && fg_pixel && w_in_cell[k] && (r_cnt[k] != CNT_MAX))
              r_cnt[k] <= r_cnt[k] + 1'b1;
          r_eval_k   <= '0;
          r_best_idx <= '0;
          r_best_cnt <= '0;
        end
        EVAL: begin
          if (w_eval_cnt > r_best_cnt) begin
            r_best_cnt <= w_eval_cnt;
            r_best_idx <= r_eval_k;
          end
          r_eval_k <= r_eval_k + 3'd1;
        end
        UPDATE: begin
          for (int k = 0; k < 5; k++) r_cnt[k] <= '0;
          if (w_win) begin
            r_sel_pulse   <= !r_cell_valid || (r_best_idx != r_active_cell);
            r_active_cell <= r_best_idx;
            r_cell_valid  <= 1'b1;
            r_hold        <= HOLD_VAL;
          end else if (w_refresh) begin
            r_hold <= HOLD_VAL;
          end else if (r_hold > 1) begin
            r_hold <= r_hold - 1'b1;
          end else if (r_hold == 1) begin
            r_hold       <= '0;
            r_cell_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Highlight overlay, refreshed only on pixel-enable cycles.
  always_ff @(posedge clk) begin
    if (rst)            r_highlight <= 1'b0;
    else if (pix_valid) r_highlight <= r_cell_valid && w_hl_hit;
  end

  assign active_cell = r_active_cell;
  assign cell_valid  = r_cell_valid;
  assign sel_pulse   = r_sel_pulse;
  assign highlight   = r_highlight;

endmodule

// File: tb/tb_cell_activity_scheduler.sv
// Purpose: randomized and directed stimulus against a frame-level reference model of the cell scheduler.
// Latency: checks sel_pulse timing relative to frame_done and highlight one cycle after each pixel.
// Backpressure: none; stimulus is only driven while the scheduler is in its accumulate phase.
module tb_cell_activity_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        pix_valid;
  logic [30:0] hCounter_in;
  logic [30:0] vCounter_in;
  logic        fg_pixel;
  logic        frame_done;
  logic [2:0]  active_cell;
  logic        cell_valid;
  logic        sel_pulse;
  logic        highlight;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int ref_cnt [5];
  bit ref_valid;
  int ref_cell;
  int ref_hold;
  bit ref_hl;

  cell_activity_scheduler dut (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .hCounter_in(hCounter_in),
    .vCounter_in(vCounter_in), .fg_pixel(fg_pixel), .frame_done(frame_done),
    .active_cell(active_cell), .cell_valid(cell_valid), .sel_pulse(sel_pulse),
    .highlight(highlight), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cell_of(input int x, input int y);
    int dx;
    if (y < 100 || y >= 180 || x < 100) return -1;
    dx = x - 100;
    if (dx / 85 > 4 || dx % 85 >= 80) return -1;
    return dx / 85;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 5; k++) ref_cnt[k] = 0;
    ref_valid = 0; ref_cell = 0; ref_hold = 0; ref_hl = 0;
  endtask

  task automatic do_reset();
    rst = 1; pix_valid = 0; frame_done = 0; fg_pixel = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic send_pix(input int x, input int y, input bit fg, input bit vld);
    int c;
    pix_valid = vld; hCounter_in = 31'(x); vCounter_in = 31'(y); fg_pixel = fg;
    @(negedge clk);
    c = cell_of(x, y);
    if (vld && fg && c >= 0 && ref_cnt[c] < 8191) ref_cnt[c]++;
    if (vld) ref_hl = ref_valid && (c == ref_cell);
    check("highlight", highlight, ref_hl);
  endtask

  task automatic fill_cell(input int k, input int n);
    for (int i = 0; i < n; i++) send_pix(100 + k*85 + i % 5, 100 + i / 5, 1'b1, 1'b1);
    pix_valid = 0;
  endtask

  task automatic noise(input int n);
    for (int i = 0; i < n; i++)
      send_pix($urandom_range(80, 560), $urandom_range(80, 200), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    pix_valid = 0;
  endtask

  // Ends a frame: predicts the selection from the counts, then checks busy, sel_pulse timing and the result.
  task automatic frame_end();
    int  best, bi;
    bit  win, refresh, exp_pulse;
    best = 0; bi = 0; refresh = 0; exp_pulse = 0;
    for (int k = 0; k < 5; k++) if (ref_cnt[k] > best) begin best = ref_cnt[k]; bi = k; end
    win = (best >= 200);
`ifdef CELL_HYST_EN
    if (win && ref_valid && bi != ref_cell && best <= ref_cnt[ref_cell] + 100) begin
      win = 0;
      refresh = (ref_cnt[ref_cell] >= 200);
    end
`endif
    if (win) begin
      exp_pulse = !ref_valid || (bi != ref_cell);
      ref_cell = bi; ref_valid = 1; ref_hold = 30;
    end else if (refresh) begin
      ref_hold = 30;
    end else if (ref_hold > 1) begin
      ref_hold--;
    end else if (ref_hold == 1) begin
      ref_hold = 0; ref_valid = 0;
    end
    for (int k = 0; k < 5; k++) ref_cnt[k] = 0;

    pix_valid = 0; frame_done = 1;
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1) frame_done = 0;
      check("busy", busy, n <= 6);
      check("sel_pulse", sel_pulse, exp_pulse && n == 7);
    end
    check("cell_valid", cell_valid, ref_valid);
    check("active_cell", active_cell, ref_cell);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    hCounter_in = 0; vCounter_in = 0;
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_cell_valid", cell_valid, 0);
    check("rst_active_cell", active_cell, 0);
    check("rst_sel_pulse", sel_pulse, 0);
    check("rst_highlight", highlight, 0);

    // Reset during the third EVAL cycle
    fill_cell(2, 300);
    frame_done = 1;
    @(negedge clk); frame_done = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    @(negedge clk); rst = 0;
    model_reset();
    check("midrst_busy", busy, 0);
    check("midrst_cell_valid", cell_valid, 0);
    check("midrst_sel_pulse", sel_pulse, 0);
    check("midrst_active", active_cell, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_pulse", sel_pulse, 0);
    end
    frame_end();

    // 300 pixels in cell 2 plus highlight edges
    fill_cell(2, 300);
    frame_end();
    send_pix(270, 100, 1'b0, 1'b1);
    send_pix(269, 100, 1'b0, 1'b1);
    send_pix(270, 100, 1'b0, 1'b1);
    send_pix(350, 100, 1'b0, 1'b0);
    send_pix(350, 100, 1'b0, 1'b1);
    send_pix(349, 179, 1'b0, 1'b1);
    send_pix(349, 180, 1'b0, 1'b1);

    // Tie between cells 1 and 3
    fill_cell(1, 250);
    fill_cell(3, 250);
    frame_end();

    // Below threshold with border pixels
    do_reset();
    fill_cell(0, 199);
    for (int i = 0; i < 100; i++) send_pix(180 + i % 5, 100 + i / 5, 1'b1, 1'b1);
    frame_end();

    // Hold expiry over 30 empty frames
    do_reset();
    fill_cell(4, 250);
    frame_end();
    for (int f = 0; f < 30; f++) frame_end();

    // Incumbent versus challenger margins
    do_reset();
    fill_cell(1, 300);
    frame_end();
    fill_cell(1, 300); fill_cell(2, 350);
    frame_end();
    fill_cell(1, 300); fill_cell(2, 401);
    frame_end();

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      fill_cell($urandom_range(0, 4), $urandom_range(0, 400));
      noise(60);
      fill_cell($urandom_range(0, 4), $urandom_range(0, 400));
      noise(40);
      frame_end();
      for (int p = 0; p < 10; p++)
        send_pix($urandom_range(90, 540), $urandom_range(90, 190), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
